// File: rtl/level_sequencer.sv
// Game-flow controller for the Frogger level mux: advances levels on goal, tracks lives on
// collision, and issues a one-cycle load strobe whenever the playfield must latch mux data.
module level_sequencer #(
    parameter int LEVEL_WIDTH = 2,
    parameter int NUM_LEVELS  = 4,
    parameter int LIVES_WIDTH = 2,
    parameter int LIVES_INIT  = 3,
    parameter int SHOW_CYCLES = 4
) (
    input  logic                   CC_LEVELSEQ_CLOCK_50,
    input  logic                   CC_LEVELSEQ_RESET_InLow,
    input  logic                   CC_LEVELSEQ_start_In,
    input  logic                   CC_LEVELSEQ_win_In,
    input  logic                   CC_LEVELSEQ_hit_In,
    output logic [LEVEL_WIDTH-1:0] CC_LEVELSEQ_select_OutBUS,
    output logic [LIVES_WIDTH-1:0] CC_LEVELSEQ_lives_OutBUS,
    output logic                   CC_LEVELSEQ_load_Out,
    output logic                   CC_LEVELSEQ_playing_Out,
    output logic                   CC_LEVELSEQ_gameover_Out,
    output logic                   CC_LEVELSEQ_victory_Out
);

    localparam int CNT_W = $clog2(SHOW_CYCLES + 1);
    localparam logic [LEVEL_WIDTH-1:0] LAST_LEVEL = LEVEL_WIDTH'(NUM_LEVELS - 1);
    localparam logic [LIVES_WIDTH-1:0] LIVES_RST  = LIVES_WIDTH'(LIVES_INIT);
    localparam logic [CNT_W-1:0]       CNT_LOAD   = CNT_W'(SHOW_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_WAIT,
        S_GAMEOVER,
        S_VICTORY
    } state_t;

    state_t                 r_state, w_next_state;
    logic [LEVEL_WIDTH-1:0] r_select, w_next_select;
    logic [LIVES_WIDTH-1:0] r_lives, w_next_lives;
    logic [CNT_W-1:0]       r_cnt, w_next_cnt;
    logic                   r_prev_start, r_prev_win, r_prev_hit;
    logic                   r_load, r_playing, r_gameover, r_victory;
    logic                   w_start_edge, w_win_edge, w_hit_edge;

    assign w_start_edge = CC_LEVELSEQ_start_In & ~r_prev_start;
    assign w_win_edge   = CC_LEVELSEQ_win_In   & ~r_prev_win;
    assign w_hit_edge   = CC_LEVELSEQ_hit_In   & ~r_prev_hit;

    always_ff @(posedge CC_LEVELSEQ_CLOCK_50 or negedge CC_LEVELSEQ_RESET_InLow) begin
        if (!CC_LEVELSEQ_RESET_InLow) begin
            r_state      <= S_IDLE;
            r_select     <= '0;
            r_lives      <= LIVES_RST;
            r_cnt        <= '0;
            r_prev_start <= 1'b0;
            r_prev_win   <= 1'b0;
            r_prev_hit   <= 1'b0;
            r_load       <= 1'b0;
            r_playing    <= 1'b0;
            r_gameover   <= 1'b0;
            r_victory    <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_select     <= w_next_select;
            r_lives      <= w_next_lives;
            r_cnt        <= w_next_cnt;
            r_prev_start <= CC_LEVELSEQ_start_In;
            r_prev_win   <= CC_LEVELSEQ_win_In;
            r_prev_hit   <= CC_LEVELSEQ_hit_In;
            // Status flags are decoded from the next state so they line up with r_state.
            r_load       <= (w_next_state == S_LOAD);
            r_playing    <= (w_next_state == S_PLAY);
            r_gameover   <= (w_next_state == S_GAMEOVER);
            r_victory    <= (w_next_state == S_VICTORY);
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_select = r_select;
        w_next_lives  = r_lives;
        w_next_cnt    = r_cnt;
        case (r_state)
            S_IDLE, S_GAMEOVER, S_VICTORY: begin
                if (w_start_edge) begin
                    w_next_state  = S_LOAD;
                    w_next_select = '0;
                    w_next_lives  = LIVES_RST;
                end
            end
            S_LOAD: w_next_state = S_PLAY;
            S_PLAY: begin
                // Collision outranks reaching the goal in the same cycle.
                if (w_hit_edge) begin
                    if (r_lives <= LIVES_WIDTH'(1)) begin
                        w_next_lives = '0;
                        w_next_state = S_GAMEOVER;
                    end else begin
                        w_next_lives = r_lives - LIVES_WIDTH'(1);
                        w_next_cnt   = CNT_LOAD;
                        w_next_state = S_WAIT;
                    end
                end else if (w_win_edge) begin
                    if (r_select == LAST_LEVEL) begin
                        w_next_state = S_VICTORY;
                    end else begin
                        w_next_select = r_select + LEVEL_WIDTH'(1);
                        w_next_cnt    = CNT_LOAD;
                        w_next_state  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_next_state = S_LOAD;
                end else begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign CC_LEVELSEQ_select_OutBUS = r_select;
    assign CC_LEVELSEQ_lives_OutBUS  = r_lives;
    assign CC_LEVELSEQ_load_Out      = r_load;
    assign CC_LEVELSEQ_playing_Out   = r_playing;
    assign CC_LEVELSEQ_gameover_Out  = r_gameover;
    assign CC_LEVELSEQ_victory_Out   = r_victory;

endmodule
